// File: rtl/wca_regbus_pkg.sv
// Shared register-bus definitions: rbusCtrl field positions, bus widths and the
// responder FSM state encoding.
package wca_regbus_pkg;

    localparam int unsigned RBUS_CLK      = 0;
    localparam int unsigned RBUS_NWE      = 1;
    localparam int unsigned RBUS_NOE      = 2;
    localparam int unsigned RBUS_NAS      = 3;
    localparam int unsigned RBUS_ADDR_LSB = 4;
    localparam int unsigned RBUS_ADDR_MSB = 11;

    localparam int unsigned RBUS_ADDR_W = 8;
    localparam int unsigned RBUS_DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } rbus_state_e;

    // Register index width; a single-register window still carries one index bit.
    function automatic int unsigned idx_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/wca_regbus_addr_decode.sv
// Address latch for the register bus: captures addr while nAddrStrobe is low and
// reports whether the latched address falls in this responder's window.
module wca_regbus_addr_decode
    import wca_regbus_pkg::*;
#(
    parameter logic [RBUS_ADDR_W-1:0] ADDR_BASE = 8'h00,
    parameter int unsigned            NREGS     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          as_n_i,
    input  logic [RBUS_ADDR_W-1:0]        addr_i,
    output logic                          hit_o,
    output logic [idx_width(NREGS)-1:0]   index_o
);

    localparam int unsigned IdxW = idx_width(NREGS);

    logic [RBUS_ADDR_W-1:0] addr_q;
    logic                   latched_q;
    logic [RBUS_ADDR_W:0]   offset;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            latched_q <= 1'b0;
        end else if (!as_n_i) begin
            addr_q    <= addr_i;
            latched_q <= 1'b1;
        end
    end

    // One extra bit so addresses below ADDR_BASE land far above NREGS instead of wrapping.
    assign offset  = {1'b0, addr_q} - {1'b0, ADDR_BASE};
    assign hit_o   = latched_q && (offset < (RBUS_ADDR_W + 1)'(NREGS));
    assign index_o = offset[IdxW-1:0];

endmodule

// File: rtl/wca_register_responder.sv
// Register-bus responder: commits bus writes into NREGS control registers and answers
// reads in its window. Define WCA_REGRESP_READBACK_EN to read back regOut, not statusIn.
module wca_register_responder
    import wca_regbus_pkg::*;
#(
    parameter logic [RBUS_ADDR_W-1:0] ADDR_BASE = 8'h00,
    parameter int unsigned            NREGS     = 4,
    parameter logic [RBUS_DATA_W-1:0] RESET_VAL = 16'h0000
) (
    input  logic                         cpuclock,
    input  logic                         reset,
    input  logic [12:0]                  rbusCtrl,
    inout  wire  [RBUS_DATA_W-1:0]       rbusData,
    input  logic [NREGS*RBUS_DATA_W-1:0] statusIn,
    output logic [NREGS*RBUS_DATA_W-1:0] regOut,
    output logic [NREGS-1:0]             wrStrobe,
    output logic [NREGS-1:0]             rdStrobe
);

    localparam int unsigned IdxW = idx_width(NREGS);

    logic            nas, nwe, nre, hit;
    logic [IdxW-1:0] index;
    logic [NREGS-1:0] sel;

    rbus_state_e                        state_q, state_d;
    logic [RBUS_DATA_W-1:0]             hold_q, hold_d;
    logic [NREGS-1:0][RBUS_DATA_W-1:0]  regs_q, regs_d;
    logic [NREGS-1:0]                   wr_strobe_q, wr_strobe_d;
    logic [NREGS-1:0]                   rd_strobe_q, rd_strobe_d;
    logic                               oe_q, oe_d;
    logic [RBUS_DATA_W-1:0]             rd_word;

    logic unused_ctrl;
    assign unused_ctrl = rbusCtrl[12] ^ rbusCtrl[RBUS_CLK];

    assign nas = rbusCtrl[RBUS_NAS];
    assign nwe = rbusCtrl[RBUS_NWE];
    assign nre = rbusCtrl[RBUS_NOE];

    wca_regbus_addr_decode #(
        .ADDR_BASE (ADDR_BASE),
        .NREGS     (NREGS)
    ) u_addr_decode (
        .clk_i   (cpuclock),
        .rst_i   (reset),
        .as_n_i  (nas),
        .addr_i  (rbusCtrl[RBUS_ADDR_MSB:RBUS_ADDR_LSB]),
        .hit_o   (hit),
        .index_o (index)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            sel[i] = (index == IdxW'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        rd_strobe_d = '0;
        oe_d        = 1'b0;
        case (state_q)
            StIdle: begin
                // Write takes priority when both strobes are low.
                if (nas && hit) begin
                    if (!nwe) begin
                        state_d = StWrite;
                        hold_d  = rbusData;
                    end else if (!nre) begin
                        state_d = StRead;
                        oe_d    = 1'b1;
                    end
                end
            end
            StWrite: begin
                if (!nas) begin
                    state_d = StIdle;
                end else if (!nwe) begin
                    hold_d = rbusData;
                end else begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (sel[i]) regs_d[i] = hold_q;
                    end
                    wr_strobe_d = sel;
                    state_d     = StIdle;
                end
            end
            StRead: begin
                if (!nas) begin
                    state_d = StIdle;
                end else if (!nre) begin
                    oe_d = 1'b1;
                end else begin
                    rd_strobe_d = sel;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge cpuclock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            regs_q      <= {NREGS{RESET_VAL}};
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            oe_q        <= oe_d;
        end
    end

`ifdef WCA_REGRESP_READBACK_EN
    logic [NREGS*RBUS_DATA_W-1:0] unused_status;
    assign unused_status = statusIn;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel[i]) rd_word = regs_q[i];
        end
    end
`else
    logic [RBUS_DATA_W-1:0] status_word;
    logic [RBUS_DATA_W-1:0] rd_data_q;

    always_comb begin
        status_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel[i]) status_word = statusIn[i*RBUS_DATA_W +: RBUS_DATA_W];
        end
    end

    // Status is snapshotted on READ entry so the bus value stays stable while driven.
    always_ff @(posedge cpuclock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if ((state_q == StIdle) && (state_d == StRead)) begin
            rd_data_q <= status_word;
        end
    end

    assign rd_word = rd_data_q;
`endif

    assign rbusData = oe_q ? rd_word : {RBUS_DATA_W{1'bz}};
    assign regOut   = regs_q;
    assign wrStrobe = wr_strobe_q;
    assign rdStrobe = rd_strobe_q;

endmodule

// File: tb/tb_wca_register_responder.sv
// Scoreboard bench for wca_register_responder (ADDR_BASE=8'h10, NREGS=4): directed cases
// followed by randomised bus transactions checked against a register-array model.
module tb_wca_register_responder;

    localparam logic [7:0]  BASE = 8'h10;
    localparam int          NR   = 4;
    localparam logic [15:0] RV   = 16'hC0DE;

    typedef struct {
        int             cyc;
        int             idx;
        logic [NR*16-1:0] regs;
    } wr_item_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [15:0] data;
        int          n;
    } rd_item_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             nas = 1'b1, nwe = 1'b1, nre = 1'b1;
    logic [7:0]       addr = 8'h00;
    logic             tb_oe = 1'b0;
    logic [15:0]      tb_data = 16'h0000;
    logic [NR*16-1:0] status_in = '0;
    logic [NR*16-1:0] reg_out;
    logic [NR-1:0]    wr_stb, rd_stb;
    logic [12:0]      ctrl;
    wire  [15:0]      bus;

    assign ctrl = {1'b0, addr, nas, nre, nwe, clk};
    assign bus  = tb_oe ? tb_data : 16'hzzzz;

    always #5 clk = ~clk;

    wca_register_responder #(
        .ADDR_BASE (BASE),
        .NREGS     (NR),
        .RESET_VAL (RV)
    ) dut (
        .cpuclock (clk),
        .reset    (rst),
        .rbusCtrl (ctrl),
        .rbusData (bus),
        .statusIn (status_in),
        .regOut   (reg_out),
        .wrStrobe (wr_stb),
        .rdStrobe (rd_stb)
    );

    int               cyc = 0;
    int               total = 0, bad = 0;
    int               drv_cnt = 0;
    wr_item_t         wq[$];
    rd_item_t         rq[$];
    logic [15:0]      model [NR];
    logic [NR*16-1:0] cur_exp;
    logic [7:0]       lat_addr = 8'h00;
    bit               lat_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NR*16-1:0] pack_model();
        logic [NR*16-1:0] r;
        for (int i = 0; i < NR; i++) r[i*16 +: 16] = model[i];
        return r;
    endfunction

    function automatic bit in_win(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + NR);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [7:0] a);
        nas  = 1'b0;
        addr = a;
        tick();
        nas       = 1'b1;
        lat_addr  = a;
        lat_valid = 1'b1;
    endtask

    // Last data word on the bus before nWriteStrobe rises is what commits.
    task automatic do_write(input logic [7:0] a, input bit new_addr, input logic [15:0] d,
                            input int n, input bit vary, input bit both);
        wr_item_t e;
        if (new_addr) addr_phase(a);
        if (lat_valid && in_win(lat_addr)) begin
            e.idx = int'(lat_addr) - int'(BASE);
            model[e.idx] = d;
            e.cyc  = cyc + n + 1;
            e.regs = pack_model();
            wq.push_back(e);
        end
        nwe   = 1'b0;
        nre   = both ? 1'b0 : 1'b1;
        tb_oe = 1'b1;
        for (int k = 0; k < n; k++) begin
            tb_data = (k == n - 1 || !vary) ? d : 16'($urandom);
            tick();
        end
        nwe   = 1'b1;
        nre   = 1'b1;
        tb_oe = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input bit new_addr, input int n,
                           input logic [15:0] sw);
        rd_item_t e;
        if (new_addr) addr_phase(a);
        status_in = {$urandom, $urandom};
        if (lat_valid && in_win(lat_addr)) begin
            e.idx = int'(lat_addr) - int'(BASE);
            status_in[e.idx*16 +: 16] = sw;
`ifdef WCA_REGRESP_READBACK_EN
            e.data = model[e.idx];
`else
            e.data = sw;
`endif
            e.cyc = cyc + n + 1;
            e.n   = n;
            rq.push_back(e);
        end
        nre = 1'b0;
        tick();
        status_in = {$urandom, $urandom};
        repeat (n - 1) tick();
        nre = 1'b1;
    endtask

    task automatic do_abort(input logic [7:0] a, input logic [15:0] d, input int k,
                            input logic [7:0] a2);
        addr_phase(a);
        nwe     = 1'b0;
        tb_oe   = 1'b1;
        tb_data = d;
        repeat (k) tick();
        nas   = 1'b0;
        addr  = a2;
        nwe   = 1'b1;
        tb_oe = 1'b0;
        tick();
        nas       = 1'b1;
        lat_addr  = a2;
        lat_valid = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        wr_item_t we;
        rd_item_t re;
        bit       bz;
        if (!rst) begin
            if (wr_stb != '0) begin
                if (wq.size() == 0) begin
                    chk("wrStrobe_spurious", 64'(wr_stb), 64'd0);
                end else begin
                    we = wq.pop_front();
                    chk("wrStrobe_idx", 64'(wr_stb), 64'd1 << we.idx);
                    chk("wrStrobe_cycle", 64'(cyc), 64'(we.cyc));
                    cur_exp = we.regs;
                end
            end else if (wq.size() != 0 && cyc > wq[0].cyc) begin
                chk("wrStrobe_missing", 64'(cyc), 64'(wq[0].cyc));
                we = wq.pop_front();
                cur_exp = we.regs;
            end
            chk("regOut", reg_out, cur_exp);

            if (tb_oe) begin
                chk("bus_contention", 64'(bus), 64'(tb_data));
            end else begin
                bz = (bus === 16'hzzzz);
                if (!bz) begin
                    if (rq.size() == 0) begin
                        chk("bus_spurious_drive", 64'(bz), 64'd1);
                    end else begin
                        chk("rbusData", 64'(bus), 64'(rq[0].data));
                        drv_cnt++;
                    end
                end
            end

            if (rd_stb != '0) begin
                if (rq.size() == 0) begin
                    chk("rdStrobe_spurious", 64'(rd_stb), 64'd0);
                end else begin
                    re = rq.pop_front();
                    chk("rdStrobe_idx", 64'(rd_stb), 64'd1 << re.idx);
                    chk("rdStrobe_cycle", 64'(cyc), 64'(re.cyc));
                    chk("read_drive_cycles", 64'(drv_cnt), 64'(re.n));
                    drv_cnt = 0;
                end
            end else if (rq.size() != 0 && cyc > rq[0].cyc) begin
                chk("rdStrobe_missing", 64'(cyc), 64'(rq[0].cyc));
                re = rq.pop_front();
                drv_cnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          op, n, k;
        logic [7:0]  a, a2;
        rd_item_t    e;
        bit          bz;

        for (int i = 0; i < NR; i++) model[i] = RV;
        cur_exp = {NR{RV}};

        #1 rst = 1'b1;
        #2;
        bz = (bus === 16'hzzzz);
        chk("reset_bus_z", 64'(bz), 64'd1);
        chk("reset_regOut", reg_out, {NR{RV}});
        chk("reset_wrStrobe", 64'(wr_stb), 64'd0);
        chk("reset_rdStrobe", 64'(rd_stb), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        do_write(8'h12, 1'b1, 16'hA5C3, 3, 1'b0, 1'b0);
        tick();
        do_read(8'h12, 1'b1, 3, 16'h1234);
        tick();

        do_write(8'h14, 1'b1, 16'hFFFF, 2, 1'b0, 1'b0);
        tick();
        do_read(8'h14, 1'b1, 2, 16'h7777);
        tick();
        do_write(8'h0F, 1'b1, 16'hFFFF, 2, 1'b0, 1'b0);
        tick();
        do_read(8'h0F, 1'b1, 2, 16'h7777);
        tick();

        do_abort(8'h11, 16'hDEAD, 2, 8'h11);
        tick();
        do_write(8'h10, 1'b1, 16'h00FF, 2, 1'b0, 1'b1);
        tick();

        do_write(8'h13, 1'b1, 16'h1111, 2, 1'b1, 1'b0);
        tick();
        do_write(8'h13, 1'b0, 16'h2222, 2, 1'b1, 1'b0);
        tick();

        // Reset in the middle of a read of word 3.
        addr_phase(8'h13);
        status_in = {$urandom, $urandom};
        e.idx = 3;
`ifdef WCA_REGRESP_READBACK_EN
        e.data = model[3];
`else
        e.data = status_in[3*16 +: 16];
`endif
        e.cyc = cyc + 1000;
        e.n   = 0;
        rq.push_back(e);
        nre = 1'b0;
        tick();
        tick();
        #2;
        chk("read_in_progress_drive", 64'(drv_cnt), 64'd1);
        rst = 1'b1;
        #1;
        bz = (bus === 16'hzzzz);
        chk("midread_reset_bus_z", 64'(bz), 64'd1);
        chk("midread_reset_regOut", reg_out, {NR{RV}});
        chk("midread_reset_rdStrobe", 64'(rd_stb), 64'd0);
        chk("midread_reset_wrStrobe", 64'(wr_stb), 64'd0);
        rq.delete();
        drv_cnt = 0;
        for (int i = 0; i < NR; i++) model[i] = RV;
        cur_exp   = {NR{RV}};
        lat_valid = 1'b0;
        nre       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int t = 0; t < 80; t++) begin
            op = $urandom_range(0, 5);
            n  = $urandom_range(1, 3);
            k  = $urandom_range(1, 2);
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                              : BASE + 8'($urandom_range(0, NR - 1));
            a2 = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                              : BASE + 8'($urandom_range(0, NR - 1));
            case (op)
                0: do_write(a, 1'b1, 16'($urandom), n, 1'b1, 1'b0);
                1: do_read(a, 1'b1, n, 16'($urandom));
                2: do_write(a, 1'b1, 16'($urandom), n, 1'b1, 1'b1);
                3: do_write(lat_addr, 1'b0, 16'($urandom), n, 1'b1, 1'b0);
                4: do_read(lat_addr, 1'b0, n, 16'($urandom));
                default: do_abort(a, 16'($urandom), k, a2);
            endcase
            repeat ($urandom_range(1, 2)) tick();
        end

        repeat (5) tick();
        chk("write_queue_drained", 64'(wq.size()), 64'd0);
        chk("read_queue_drained", 64'(rq.size()), 64'd0);
        chk("final_regOut", reg_out, pack_model());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
